// File: rtl/steer_en_mc.sv
// steer_en_mc : multi-channel rider detect / steer enable
//
// Sums NUM_CELLS load-cell readings into a total weight and a signed
// left-minus-right imbalance on every sample strobe. A three-state
// controller uses these to decide whether a rider is present, and whether
// the rider has stood balanced for long enough to allow steering.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   OFF   | no rider; rider_off=1, en_steer=0
//   WAIT  | rider present, timing a balanced stance; en_steer=0
//   STEER | rider present and settled; en_steer=1
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   vld          in   one-clk strobe, ld_cells valid this cycle
//   ld_cells     in   packed readings, cell i at [i*LD_W +: LD_W]
//                     (cells 0..NUM_CELLS/2-1 left, the rest right)
//   ld_sum       out  registered total weight, SUM_W bits
//   ld_cell_diff out  registered signed left-minus-right, SUM_W+1 bits
//   rider_off    out  high when no rider is on the platform
//   en_steer     out  high when steering is permitted

module steer_en_mc #(
    parameter int              NUM_CELLS    = 2,
    parameter int              LD_W         = 12,
    parameter logic [LD_W-1:0] MIN_RIDER_WT = 'h200,
    parameter logic [LD_W-1:0] WT_HYST      = 'h040,
    parameter int              TMR_CYC      = 67108864,
    localparam int             SUM_W        = LD_W + $clog2(NUM_CELLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld,
    input  logic [NUM_CELLS*LD_W-1:0] ld_cells,
    output logic [SUM_W-1:0]          ld_sum,
    output logic signed [SUM_W:0]     ld_cell_diff,
    output logic                      rider_off,
    output logic                      en_steer
);

    localparam int HALF = NUM_CELLS / 2;
    // A single-cycle timer would give $clog2 of zero; keep at least one bit.
    localparam int TW   = ($clog2(TMR_CYC) < 1) ? 1 : $clog2(TMR_CYC);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2
    } state_t;

    state_t state;
    logic [TW-1:0] timer;

    logic [SUM_W-1:0]      left_sum;
    logic [SUM_W-1:0]      right_sum;
    logic [SUM_W-1:0]      sum_next;
    logic signed [SUM_W:0] diff_next;

    logic [SUM_W:0]   diff_abs;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W:0]   bal_lim;
    logic [SUM_W:0]   lean_lim;
    logic [SUM_W-1:0] off_thr;
    logic             present_hi;
    logic             present_lo;
    logic             balanced;
    logic             leaning;

    always_comb begin
        left_sum  = '0;
        right_sum = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (i < HALF)
                left_sum  = left_sum  + SUM_W'(ld_cells[i*LD_W +: LD_W]);
            else
                right_sum = right_sum + SUM_W'(ld_cells[i*LD_W +: LD_W]);
        end
    end

    // Each half sums at most NUM_CELLS/2 readings, so both halves and their
    // total fit SUM_W; the extra sign bit makes the difference exact.
    assign sum_next  = left_sum + right_sum;
    assign diff_next = $signed({1'b0, left_sum}) - $signed({1'b0, right_sum});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_sum       <= '0;
            ld_cell_diff <= '0;
        end else if (vld) begin
            ld_sum       <= sum_next;
            ld_cell_diff <= diff_next;
        end
    end

    // The most negative difference is -(right max), well above -2^SUM_W,
    // so negation cannot overflow at SUM_W+1 bits.
    assign diff_abs = ld_cell_diff[SUM_W] ? $unsigned(-ld_cell_diff)
                                          : $unsigned(ld_cell_diff);
    assign sum_ext  = {1'b0, ld_sum};
    assign bal_lim  = {3'b000, ld_sum[SUM_W-1:2]};
    assign lean_lim = sum_ext - {5'b00000, ld_sum[SUM_W-1:4]};
    assign off_thr  = SUM_W'(MIN_RIDER_WT - WT_HYST);

    assign present_hi = ld_sum > SUM_W'(MIN_RIDER_WT);
    assign present_lo = ld_sum < off_thr;
    assign balanced   = diff_abs < bal_lim;
    assign leaning    = diff_abs > lean_lim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_OFF;
            timer     <= '0;
            rider_off <= 1'b1;
            en_steer  <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (present_hi) begin
                        state     <= ST_WAIT;
                        timer     <= '0;
                        rider_off <= 1'b0;
                        en_steer  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (present_lo) begin
                        state     <= ST_OFF;
                        rider_off <= 1'b1;
                        en_steer  <= 1'b0;
                    end else if (!balanced) begin
                        timer <= '0;
                    end else if (timer == TW'(TMR_CYC - 1)) begin
                        state    <= ST_STEER;
                        en_steer <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STEER: begin
                    if (present_lo) begin
                        state     <= ST_OFF;
                        rider_off <= 1'b1;
                        en_steer  <= 1'b0;
                    end else if (leaning) begin
                        state    <= ST_WAIT;
                        timer    <= '0;
                        en_steer <= 1'b0;
                    end
                    // Between balanced and leaning the rider keeps steering.
                end
                default: begin
                    state     <= ST_OFF;
                    timer     <= '0;
                    rider_off <= 1'b1;
                    en_steer  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_steer_en_mc.sv
module tb_steer_en_mc;

    localparam int TMR  = 16;
    localparam int MINW = 'h200;
    localparam int HYST = 'h040;

    logic clk = 1'b0;
    logic rst;
    logic vld;
    logic [11:0] c [8];   // c[0..3] feed left cells, c[4..7] feed right cells

    logic [23:0] cells2;
    logic [47:0] cells4;
    logic [95:0] cells8;

    logic [12:0]        s2;
    logic signed [13:0] d2;
    logic               off2, en2;
    logic [13:0]        s4;
    logic signed [14:0] d4;
    logic               off4, en4;
    logic [14:0]        s8;
    logic signed [15:0] d8;
    logic               off8, en8;

    always #5 clk = ~clk;

    always_comb begin
        cells2 = '0;
        cells4 = '0;
        cells8 = '0;
        for (int j = 0; j < 1; j++) begin
            cells2[j*12 +: 12]     = c[j];
            cells2[(1+j)*12 +: 12] = c[4+j];
        end
        for (int j = 0; j < 2; j++) begin
            cells4[j*12 +: 12]     = c[j];
            cells4[(2+j)*12 +: 12] = c[4+j];
        end
        for (int j = 0; j < 4; j++) begin
            cells8[j*12 +: 12]     = c[j];
            cells8[(4+j)*12 +: 12] = c[4+j];
        end
    end

    steer_en_mc #(.NUM_CELLS(2), .LD_W(12), .TMR_CYC(TMR)) u_n2 (
        .clk(clk), .rst(rst), .vld(vld), .ld_cells(cells2),
        .ld_sum(s2), .ld_cell_diff(d2), .rider_off(off2), .en_steer(en2));
    steer_en_mc #(.NUM_CELLS(4), .LD_W(12), .TMR_CYC(TMR)) u_n4 (
        .clk(clk), .rst(rst), .vld(vld), .ld_cells(cells4),
        .ld_sum(s4), .ld_cell_diff(d4), .rider_off(off4), .en_steer(en4));
    steer_en_mc #(.NUM_CELLS(8), .LD_W(12), .TMR_CYC(TMR)) u_n8 (
        .clk(clk), .rst(rst), .vld(vld), .ld_cells(cells8),
        .ld_sum(s8), .ld_cell_diff(d8), .rider_off(off8), .en_steer(en8));

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] diff;
        logic        off;
        logic        en;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: rider present / steering permitted plus a count of
    // consecutive balanced clocks while waiting, all in plain integers.
    int ncell [3] = '{2, 4, 8};
    int m_sum [3];
    int m_diff[3];
    int m_cnt [3];
    bit m_off [3];
    bit m_en  [3];

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = 0; m_diff[k] = 0; m_cnt[k] = 0;
            m_off[k] = 1'b1; m_en[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge(bit v);
        for (int k = 0; k < 3; k++) begin
            int h, l, r, ab;
            bit hi, lo, bal, lean;
            hi   = m_sum[k] > MINW;
            lo   = m_sum[k] < MINW - HYST;
            ab   = (m_diff[k] < 0) ? -m_diff[k] : m_diff[k];
            bal  = ab < m_sum[k] / 4;
            lean = ab > m_sum[k] - m_sum[k] / 16;
            if (m_off[k]) begin
                if (hi) begin m_off[k] = 1'b0; m_cnt[k] = 0; end
            end else if (lo) begin
                m_off[k] = 1'b1; m_en[k] = 1'b0;
            end else if (!m_en[k]) begin
                if (!bal)                m_cnt[k] = 0;
                else if (m_cnt[k] == TMR - 1) m_en[k] = 1'b1;
                else                     m_cnt[k]++;
            end else if (lean) begin
                m_en[k] = 1'b0; m_cnt[k] = 0;
            end
            if (v) begin
                h = ncell[k] / 2;
                l = 0; r = 0;
                for (int j = 0; j < h; j++) begin
                    l += int'(c[j]);
                    r += int'(c[4+j]);
                end
                m_sum[k]  = l + r;
                m_diff[k] = l - r;
            end
        end
    endfunction

    function automatic exp_t mk(int k);
        exp_t e;
        e.sum  = m_sum[k];
        e.diff = m_diff[k];
        e.off  = m_off[k];
        e.en   = m_en[k];
        return e;
    endfunction

    task automatic cyc(input bit v);
        vld = v;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_edge(v);
        q0.push_back(mk(0));
        q1.push_back(mk(1));
        q2.push_back(mk(2));
        vld = 1'b0;
    endtask

    task automatic set_all(input logic [11:0] l, input logic [11:0] r);
        for (int j = 0; j < 4; j++) begin
            c[j]   = l;
            c[4+j] = r;
        end
    endtask

    task automatic sample(input logic [11:0] l, input logic [11:0] r, input int idle);
        set_all(l, r);
        cyc(1'b1);
        repeat (idle) cyc(1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("n2.ld_sum",   int'(s2),   int'(e.sum));
            chk("n2.diff",     int'(d2),   int'(e.diff));
            chk("n2.rider_off", int'(off2), int'(e.off));
            chk("n2.en_steer", int'(en2),  int'(e.en));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("n4.ld_sum",   int'(s4),   int'(e.sum));
            chk("n4.diff",     int'(d4),   int'(e.diff));
            chk("n4.rider_off", int'(off4), int'(e.off));
            chk("n4.en_steer", int'(en4),  int'(e.en));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("n8.ld_sum",   int'(s8),   int'(e.sum));
            chk("n8.diff",     int'(d8),   int'(e.diff));
            chk("n8.rider_off", int'(off8), int'(e.off));
            chk("n8.en_steer", int'(en8),  int'(e.en));
        end
    end

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        set_all(12'h000, 12'h000);
        model_reset();
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);

        // Balanced rider boards, waits 16 clks, then steers.
        sample(12'h100, 12'h100, 20);
        // Hard lean on the left drops steering; re-balance restores it.
        sample(12'h3F0, 12'h000, 3);
        sample(12'h100, 12'h100, 20);
        // Lean back to WAIT, count partway, then an unbalanced sample
        // (sum 0x400, diff +0x120 on the four-cell unit) restarts the count.
        sample(12'h3F0, 12'h000, 2);
        sample(12'h100, 12'h100, 11);
        sample(12'h148, 12'h0B8, 2);
        sample(12'h100, 12'h100, 20);
        // Hysteresis walk: four-cell sums 0x400,0x1D0,0x1B0,0x1F0,0x210.
        sample(12'h100, 12'h100, 2);
        sample(12'h074, 12'h074, 2);
        sample(12'h06C, 12'h06C, 2);
        sample(12'h07C, 12'h07C, 2);
        sample(12'h084, 12'h084, 2);
        // Into STEER, then step off entirely.
        sample(12'h100, 12'h100, 20);
        sample(12'h000, 12'h000, 3);

        // Asynchronous reset between edges while waiting.
        sample(12'h100, 12'h100, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async.n4.ld_sum",    int'(s4),   0);
        chk("async.n4.diff",      int'(d4),   0);
        chk("async.n4.rider_off", int'(off4), 1);
        chk("async.n4.en_steer",  int'(en4),  0);
        chk("async.n8.ld_sum",    int'(s8),   0);
        chk("async.n8.rider_off", int'(off8), 1);
        model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        cyc(1'b0);
        rst = 1'b0;
        repeat (4) cyc(1'b0);
        sample(12'h100, 12'h100, 20);

        // Continuous vld with fresh random balanced-ish readings.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 8; j++) c[j] = 12'(12'h0F0 + $urandom_range(0, 31));
            cyc(1'b1);
        end

        // Random mix of stances, weights and idle gaps.
        for (int i = 0; i < 120; i++) begin
            int mode;
            int base;
            mode = $urandom_range(0, 3);
            base = $urandom_range(0, 'h1FF);
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0: c[j] = 12'(base + $urandom_range(0, 15));
                    1: c[j] = (j < 4) ? 12'(base + 'h100) : 12'($urandom_range(0, 15));
                    2: c[j] = 12'($urandom_range(0, 'hFFF));
                    default: c[j] = 12'($urandom_range(0, 'h60));
                endcase
            end
            cyc(1'b1);
            repeat ($urandom_range(0, 24)) cyc(1'b0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
